// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Memory-access stage of the 5-stage RISC-V pipeline. It takes the EX/MEM
// fields, issues word-sized load/store requests to the data cache, and tracks
// outstanding cache accesses with a two-state FSM (IDLE / WAIT). It also holds
// the MEM/WB pipeline register, picks the write-back value, and keeps
// performance counters plus a sticky misalignment flag.
//
// The whole pipeline freezes while DCACHE_stall is high. Upstream keeps the
// EX/MEM fields stable during a stall, so the cache requests stay stable too.
//
// Parameters
//   BIT_W : datapath width
//   CNT_W : width of the performance counters
//
// Ports
//   clk, rst_n       : clock; asynchronous active-low reset
//   alu_result_in    : EX/MEM ALU result / memory byte address
//   mem_wdata_in     : EX/MEM store data
//   rd_in            : EX/MEM destination register
//   PC_plus_4_in     : EX/MEM link value for jal/jalr
//   memrd_in         : EX/MEM load
//   memwr_in         : EX/MEM store
//   mem2reg_in       : EX/MEM write-back from memory
//   regwr_in         : EX/MEM register write enable
//   jump_in          : EX/MEM jal/jalr
//   DCACHE_ren       : cache read request (combinational)
//   DCACHE_wen       : cache write request (combinational)
//   DCACHE_addr      : cache word address (combinational)
//   DCACHE_wdata     : cache write data (combinational)
//   DCACHE_rdata     : cache read data, valid in the completion cycle
//   DCACHE_stall     : cache busy, pipeline freeze
//   wb_data          : MEM/WB write-back value
//   wb_rd            : MEM/WB destination register
//   wb_regwr         : MEM/WB register write enable
//   misalign         : sticky flag for a load/store with a non-word address
//   load_cnt         : completed loads (wraps)
//   store_cnt        : completed stores (wraps)
//   stall_cnt        : cycles with DCACHE_stall high (wraps)
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int BIT_W = 32,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BIT_W-1:0]   alu_result_in,
  input  logic [BIT_W-1:0]   mem_wdata_in,
  input  logic [4:0]         rd_in,
  input  logic [BIT_W-1:0]   PC_plus_4_in,
  input  logic               memrd_in,
  input  logic               memwr_in,
  input  logic               mem2reg_in,
  input  logic               regwr_in,
  input  logic               jump_in,
  output logic               DCACHE_ren,
  output logic               DCACHE_wen,
  output logic [BIT_W-3:0]   DCACHE_addr,
  output logic [BIT_W-1:0]   DCACHE_wdata,
  input  logic [BIT_W-1:0]   DCACHE_rdata,
  input  logic               DCACHE_stall,
  output logic [BIT_W-1:0]   wb_data,
  output logic [4:0]         wb_rd,
  output logic               wb_regwr,
  output logic               misalign,
  output logic [CNT_W-1:0]   load_cnt,
  output logic [CNT_W-1:0]   store_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_state_s;
  logic              pend_store_r;      // kind of the access parked in WAIT
  logic              pend_store_next_s;
  logic              req_s;
  logic              load_done_s;
  logic              store_done_s;
  logic              misalign_hit_s;
  logic [BIT_W-1:0]  wb_data_next_s;

  // Cache request decode; a simultaneous load+store is issued as a store only.
  always_comb begin
    DCACHE_ren   = memrd_in & ~memwr_in;
    DCACHE_wen   = memwr_in;
    DCACHE_addr  = alu_result_in[BIT_W-1:2];
    DCACHE_wdata = mem_wdata_in;
    req_s        = (memrd_in & ~memwr_in) | memwr_in;
  end

  // Misalignment detect: the access itself still goes out word-aligned.
  always_comb begin
    misalign_hit_s = 1'b0;
    if ((memrd_in | memwr_in) && (alu_result_in[1:0] != 2'b00)) begin
      misalign_hit_s = 1'b1;
    end else begin
      misalign_hit_s = 1'b0;
    end
  end

  // FSM next-state and completion decode.
  always_comb begin
    next_state_s      = state_r;
    pend_store_next_s = pend_store_r;
    load_done_s       = 1'b0;
    store_done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (DCACHE_stall) begin
            // Miss: park the access and remember whether it is a store.
            next_state_s      = WAIT;
            pend_store_next_s = memwr_in;
          end else begin
            // Single-cycle hit completes right here.
            next_state_s = IDLE;
            load_done_s  = memrd_in & ~memwr_in;
            store_done_s = memwr_in;
          end
        end else begin
          // A stall without a request is only counted, never waited on.
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (!DCACHE_stall) begin
          // Stall released: this is the completion cycle of the parked access.
          next_state_s = IDLE;
          load_done_s  = ~pend_store_r;
          store_done_s = pend_store_r;
        end else begin
          next_state_s = WAIT;
        end
      end
      default: begin
        next_state_s      = IDLE;
        pend_store_next_s = 1'b0;
      end
    endcase
  end

  // Write-back source select: memory data, then link value, then ALU result.
  always_comb begin
    wb_data_next_s = alu_result_in;
    if (mem2reg_in) begin
      wb_data_next_s = DCACHE_rdata;
    end else if (jump_in) begin
      wb_data_next_s = PC_plus_4_in;
    end else begin
      wb_data_next_s = alu_result_in;
    end
  end

  // FSM state register; reset drops any parked access without completing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      pend_store_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      pend_store_r <= pend_store_next_s;
    end
  end

  // MEM/WB pipeline register, frozen while the cache stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data  <= {BIT_W{1'b0}};
      wb_rd    <= 5'd0;
      wb_regwr <= 1'b0;
    end else if (!DCACHE_stall) begin
      wb_data  <= wb_data_next_s;
      wb_rd    <= rd_in;
      wb_regwr <= regwr_in;
    end else begin
      wb_data  <= wb_data;
      wb_rd    <= wb_rd;
      wb_regwr <= wb_regwr;
    end
  end

  // Sticky misalignment flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else if (misalign_hit_s) begin
      misalign <= 1'b1;
    end else begin
      misalign <= misalign;
    end
  end

  // Completed-load counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt <= {CNT_W{1'b0}};
    end else if (load_done_s) begin
      load_cnt <= load_cnt + CNT_ONE;
    end else begin
      load_cnt <= load_cnt;
    end
  end

  // Completed-store counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_cnt <= {CNT_W{1'b0}};
    end else if (store_done_s) begin
      store_cnt <= store_cnt + CNT_ONE;
    end else begin
      store_cnt <= store_cnt;
    end
  end

  // Stall-cycle counter, independent of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (DCACHE_stall) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed bench for mem_wb_stage, built with CNT_W = 4 so counter wrap is
// reachable. A behavioural model tracks what the outputs must be from the
// stage rules (a request seen with the stall low completes; the MEM/WB
// register follows the inputs unless stalled). A compare process checks every
// output against the model on each falling edge. Hand-computed literal checks
// pin the model at the interesting points of each scenario.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int BIT_W   = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [BIT_W-1:0]  alu_result_in = '0;
  logic [BIT_W-1:0]  mem_wdata_in = '0;
  logic [4:0]        rd_in = '0;
  logic [BIT_W-1:0]  PC_plus_4_in = '0;
  logic              memrd_in = 1'b0;
  logic              memwr_in = 1'b0;
  logic              mem2reg_in = 1'b0;
  logic              regwr_in = 1'b0;
  logic              jump_in = 1'b0;
  logic              DCACHE_ren;
  logic              DCACHE_wen;
  logic [BIT_W-3:0]  DCACHE_addr;
  logic [BIT_W-1:0]  DCACHE_wdata;
  logic [BIT_W-1:0]  DCACHE_rdata = '0;
  logic              DCACHE_stall = 1'b0;
  logic [BIT_W-1:0]  wb_data;
  logic [4:0]        wb_rd;
  logic              wb_regwr;
  logic              misalign;
  logic [CNT_W-1:0]  load_cnt;
  logic [CNT_W-1:0]  store_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.BIT_W(BIT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in),
    .rd_in(rd_in), .PC_plus_4_in(PC_plus_4_in),
    .memrd_in(memrd_in), .memwr_in(memwr_in), .mem2reg_in(mem2reg_in),
    .regwr_in(regwr_in), .jump_in(jump_in),
    .DCACHE_ren(DCACHE_ren), .DCACHE_wen(DCACHE_wen),
    .DCACHE_addr(DCACHE_addr), .DCACHE_wdata(DCACHE_wdata),
    .DCACHE_rdata(DCACHE_rdata), .DCACHE_stall(DCACHE_stall),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .misalign(misalign), .load_cnt(load_cnt), .store_cnt(store_cnt),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [BIT_W-1:0] m_wb_data = '0;
  logic [4:0]       m_wb_rd = '0;
  logic             m_wb_regwr = 1'b0;
  logic             m_mis = 1'b0;
  int               m_load = 0;
  int               m_store = 0;
  int               m_stall = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wb_data <= '0; m_wb_rd <= '0; m_wb_regwr <= 1'b0; m_mis <= 1'b0;
      m_load <= 0; m_store <= 0; m_stall <= 0;
    end else begin
      if ((memrd_in || memwr_in) && (alu_result_in % 4 != 0)) m_mis <= 1'b1;
      if (DCACHE_stall) begin
        m_stall <= (m_stall + 1) % CNT_MOD;
      end else begin
        if (memwr_in)      m_store <= (m_store + 1) % CNT_MOD;
        else if (memrd_in) m_load  <= (m_load + 1) % CNT_MOD;
        m_wb_rd    <= rd_in;
        m_wb_regwr <= regwr_in;
        m_wb_data  <= mem2reg_in ? DCACHE_rdata : (jump_in ? PC_plus_4_in : alu_result_in);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("ren",       32'(DCACHE_ren),   32'(memrd_in && !memwr_in));
    chk("wen",       32'(DCACHE_wen),   32'(memwr_in));
    chk("addr",      32'(DCACHE_addr),  alu_result_in / 4);
    chk("wdata",     DCACHE_wdata,      mem_wdata_in);
    chk("wb_data",   wb_data,           m_wb_data);
    chk("wb_rd",     32'(wb_rd),        32'(m_wb_rd));
    chk("wb_regwr",  32'(wb_regwr),     32'(m_wb_regwr));
    chk("misalign",  32'(misalign),     32'(m_mis));
    chk("load_cnt",  32'(load_cnt),     32'(m_load));
    chk("store_cnt", 32'(store_cnt),    32'(m_store));
    chk("stall_cnt", 32'(stall_cnt),    32'(m_stall));
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic jmp, input logic [4:0] dst, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] pc4,
                        input logic [31:0] rdat, input logic stl);
    @(posedge clk);
    #1;
    memrd_in = rd; memwr_in = wr; mem2reg_in = m2r; regwr_in = rw; jump_in = jmp;
    rd_in = dst; alu_result_in = addr; mem_wdata_in = wd; PC_plus_4_in = pc4;
    DCACHE_rdata = rdat; DCACHE_stall = stl;
  endtask

  task automatic set_idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wb_data",   wb_data, 32'h0);
    chk("rst_wb_regwr",  32'(wb_regwr), 32'h0);
    chk("rst_load_cnt",  32'(load_cnt), 32'h0);
    chk("rst_misalign",  32'(misalign), 32'h0);
    #2 rst_n = 1'b1;
    set_idle();

    // Load hit at 0x100.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    chk("lh_ren",  32'(DCACHE_ren), 32'h1);
    chk("lh_addr", 32'(DCACHE_addr), 32'h40);

    // Store miss at 0x204, stall high for 4 cycles; load result must be visible and held.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h204, 32'h12345678, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("sm_wen",     32'(DCACHE_wen), 32'h1);
      chk("sm_addr",    32'(DCACHE_addr), 32'h81);
      chk("sm_wdata",   DCACHE_wdata, 32'h12345678);
      chk("lh_wb_data", wb_data, 32'hDEADBEEF);
      chk("lh_wb_rd",   32'(wb_rd), 32'h5);
      chk("lh_load",    32'(load_cnt), 32'h1);
      chk("sm_store0",  32'(store_cnt), 32'h0);
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h204, 32'h12345678, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("sm_stall4",  32'(stall_cnt), 32'h4);
    chk("sm_store0b", 32'(store_cnt), 32'h0);
    chk("sm_hold",    wb_data, 32'hDEADBEEF);

    // jal write-back.
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h0, 32'h0, 32'h18, 32'h0, 1'b0);
    @(negedge clk);
    chk("sm_store1",  32'(store_cnt), 32'h1);
    chk("sm_wb_data", wb_data, 32'h204);
    chk("jal_noreq",  32'(DCACHE_ren | DCACHE_wen), 32'h0);

    // Misaligned load at 0x103.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 32'h103, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
    @(negedge clk);
    chk("jal_wb_data", wb_data, 32'h18);
    chk("jal_wb_rd",   32'(wb_rd), 32'h1);
    chk("mis_addr",    32'(DCACHE_addr), 32'h40);

    // Aligned load+store together counts as a store.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h8, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("mis_set",   32'(misalign), 32'h1);
    chk("mis_load",  32'(load_cnt), 32'h2);
    chk("rw_ren",    32'(DCACHE_ren), 32'h0);
    chk("rw_wen",    32'(DCACHE_wen), 32'h1);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'hC, 32'h0, 32'h0, 32'h11, 1'b0);
    @(negedge clk);
    chk("rw_store",  32'(store_cnt), 32'h2);
    chk("rw_load",   32'(load_cnt), 32'h2);
    set_idle();
    @(negedge clk);
    chk("mis_sticky", 32'(misalign), 32'h1);

    // Reset in the middle of a load miss.
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h40, 32'h0, 32'h0, 32'h77, 1'b1);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h40, 32'h0, 32'h0, 32'h77, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rm_wb_data",  wb_data, 32'h0);
    chk("rm_load",     32'(load_cnt), 32'h0);
    chk("rm_stall",    32'(stall_cnt), 32'h0);
    chk("rm_misalign", 32'(misalign), 32'h0);
    @(posedge clk);
    #2;
    memrd_in = 1'b0; mem2reg_in = 1'b0; regwr_in = 1'b0; rd_in = 5'd0;
    alu_result_in = 32'h0; DCACHE_stall = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    set_idle();
    @(negedge clk);
    chk("rm_load_after", 32'(load_cnt), 32'h0);
    chk("rm_regwr",      32'(wb_regwr), 32'h0);

    // 17 load hits wrap a 4-bit counter to 1.
    for (int i = 0; i < 17; i++) begin
      set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'h10, 32'h0, 32'h0, 32'h1000 + 32'(i), 1'b0);
    end
    set_idle();
    @(negedge clk);
    chk("wrap_load", 32'(load_cnt), 32'h1);
    chk("wrap_data", wb_data, 32'h1010);

    set_idle();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
